// File: rtl/jtkcpu_shifter.sv
// jtkcpu_shifter
// Multi-cycle shift/rotate engine for the KCPU datapath. Each enabled clock
// applies up to STEP single-bit steps to a working register. Operations with
// a zero count, and pass mode, complete on the launch edge itself.
//
// Parameters
//   DW    data width (>= 8)
//   CW    shift-count width, so the largest count is 2^CW-1
//   STEP  bits shifted per cen cycle (1, 2 or 4)
//
// Ports
//   rst    asynchronous reset, active-high
//   clk    clock
//   cen    clock enable; every register advances only when cen=1
//   start  launch request, accepted only while idle
//   mode   0 LSR, 1 ASR, 2 ASL, 3 ROR through C, 4 ROL through C,
//          5 ROR plain, 6 ROL plain, 7 pass
//   din    operand
//   cnt    shift count
//   cin    incoming carry
//   busy   operation in progress
//   done   one-cen-cycle pulse; the result is valid
//   dout   result (shows intermediate values while busy)
//   c_out, v_out, z_out, n_out  carry, overflow, zero and negative flags
module jtkcpu_shifter #(
  parameter int DW   = 16,
  parameter int CW   = 4,
  parameter int STEP = 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] cnt,
  input  logic          cin,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] dout,
  output logic          c_out,
  output logic          v_out,
  output logic          z_out,
  output logic          n_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] M_LSR  = 3'd0;
  localparam logic [2:0] M_ASR  = 3'd1;
  localparam logic [2:0] M_ASL  = 3'd2;
  localparam logic [2:0] M_RORC = 3'd3;
  localparam logic [2:0] M_ROLC = 3'd4;
  localparam logic [2:0] M_ROR  = 3'd5;
  localparam logic [2:0] M_ROL  = 3'd6;
  localparam logic [2:0] M_PASS = 3'd7;

  localparam logic [CW:0] STEP_W = (CW+1)'(STEP);

  typedef struct packed {
    logic [DW-1:0] w;
    logic          c;
    logic          v;
  } step_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] rem_reg,   rem_next;
  logic [2:0]    mode_reg,  mode_next;
  logic [DW-1:0] dout_reg,  dout_next;
  logic          c_reg,     c_next;
  logic          v_reg,     v_next;
  logic          done_reg,  done_next;

  // One single-bit step. C always receives the bit that leaves the word;
  // v flags an MSB change for the modes where that signals overflow.
  function automatic step_t shift_one(input logic [2:0] m,
                                      input logic [DW-1:0] w,
                                      input logic c);
    step_t s;
    s.w = w;
    s.c = c;
    s.v = 1'b0;
    case (m)
      M_LSR:  begin s.w = {1'b0,    w[DW-1:1]}; s.c = w[0];    end
      M_ASR:  begin s.w = {w[DW-1], w[DW-1:1]}; s.c = w[0];    end
      M_ASL:  begin s.w = {w[DW-2:0], 1'b0};    s.c = w[DW-1]; end
      M_RORC: begin s.w = {c,       w[DW-1:1]}; s.c = w[0];    end
      M_ROLC: begin s.w = {w[DW-2:0], c};       s.c = w[DW-1]; end
      M_ROR:  begin s.w = {w[0],    w[DW-1:1]}; s.c = w[0];    end
      M_ROL:  begin s.w = {w[DW-2:0], w[DW-1]}; s.c = w[DW-1]; end
      default: ;
    endcase
    if (m == M_ASL || m == M_ROLC || m == M_ROL)
      s.v = s.w[DW-1] ^ w[DW-1];
    return s;
  endfunction

  logic [CW:0] rem_ext;
  logic [CW:0] rem_left;
  logic        last_step;

  assign rem_ext   = {1'b0, rem_reg};
  assign last_step = (rem_ext <= STEP_W);
  assign rem_left  = last_step ? '0 : rem_ext - STEP_W;

  // Chain of STEP single-bit stages. Stage gi is only applied while more
  // than gi bits remain, which realises k = min(STEP, remaining).
  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_step
      logic [DW-1:0] w_in;
      logic          c_in;
      logic          v_in;
      logic [DW-1:0] w_o;
      logic          c_o;
      logic          v_o;
      logic          en;
      step_t         s;

      if (gi == 0) begin : g_first
        assign w_in = dout_reg;
        assign c_in = c_reg;
        assign v_in = 1'b0;
      end else begin : g_next
        assign w_in = g_step[gi-1].w_o;
        assign c_in = g_step[gi-1].c_o;
        assign v_in = g_step[gi-1].v_o;
      end

      assign en  = (rem_ext > (CW+1)'(gi));
      assign s   = shift_one(mode_reg, w_in, c_in);
      assign w_o = en ? s.w : w_in;
      assign c_o = en ? s.c : c_in;
      assign v_o = v_in | (en & s.v);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    mode_next  = mode_reg;
    dout_next  = dout_reg;
    c_next     = c_reg;
    v_next     = v_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          // The operand is loaded on every launch; a trivial operation is
          // already complete, otherwise RUN starts shifting it next edge.
          mode_next = mode;
          dout_next = din;
          c_next    = cin;
          v_next    = 1'b0;
          if (cnt == '0 || mode == M_PASS) begin
            rem_next  = '0;
            done_next = 1'b1;
          end else begin
            rem_next   = cnt;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        dout_next = g_step[STEP-1].w_o;
        c_next    = g_step[STEP-1].c_o;
        v_next    = v_reg | g_step[STEP-1].v_o;
        rem_next  = rem_left[CW-1:0];
        if (last_step) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      mode_reg  <= '0;
      dout_reg  <= '0;
      c_reg     <= 1'b0;
      v_reg     <= 1'b0;
      done_reg  <= 1'b0;
    end else if (cen) begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      mode_reg  <= mode_next;
      dout_reg  <= dout_next;
      c_reg     <= c_next;
      v_reg     <= v_next;
      done_reg  <= done_next;
    end
  end

  assign busy  = (state_reg == RUN);
  assign done  = done_reg;
  assign dout  = dout_reg;
  assign c_out = c_reg;
  assign v_out = v_reg;
  // Z and N follow the working register, so they track every step.
  assign z_out = ~|dout_reg;
  assign n_out = dout_reg[DW-1];

endmodule

// File: tb/tb_jtkcpu_shifter.sv
module tb_jtkcpu_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        start;
  logic [2:0]  mode;
  logic [15:0] din;
  logic [3:0]  cnt;
  logic        cin;

  logic        busy1, done1, c1, v1, z1, n1;
  logic [15:0] dout1;
  logic        busy4, done4, c4, v4, z4, n4;
  logic [15:0] dout4;

  int n_checks = 0;
  int n_pass   = 0;
  logic cen_tog = 1'b0;

  always #5 clk = ~clk;

  jtkcpu_shifter #(.DW(16), .CW(4), .STEP(1)) u_s1 (
    .rst(rst), .clk(clk), .cen(cen), .start(start), .mode(mode), .din(din),
    .cnt(cnt), .cin(cin), .busy(busy1), .done(done1), .dout(dout1),
    .c_out(c1), .v_out(v1), .z_out(z1), .n_out(n1)
  );

  jtkcpu_shifter #(.DW(16), .CW(4), .STEP(4)) u_s4 (
    .rst(rst), .clk(clk), .cen(cen), .start(start), .mode(mode), .din(din),
    .cnt(cnt), .cin(cin), .busy(busy4), .done(done4), .dout(dout4),
    .c_out(c4), .v_out(v4), .z_out(z4), .n_out(n4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Whole-operation reference: closed-form shifts and rotates of the
  // operand (17-bit ring for the through-carry rotates).
  function automatic void ref_model(input logic [2:0] m, input logic [15:0] d,
                                    input logic [3:0] n, input logic ci,
                                    output logic [15:0] r, output logic c,
                                    output logic v);
    int ni;
    logic [16:0] x0, x;
    logic b0;
    ni = int'(n);
    r = d; c = ci; v = 1'b0;
    x0 = {ci, d};
    if (ni == 0 || m == 3'd7) return;
    case (m)
      3'd0: begin r = d >> ni; c = d[ni-1]; end
      3'd1: begin r = $signed(d) >>> ni; c = d[ni-1]; end
      3'd2: begin
        r = d << ni; c = d[16-ni];
        b0 = d[15];
        for (int i = 1; i <= ni; i++) if (d[15-i] != b0) v = 1'b1;
      end
      3'd3: begin
        x = (x0 >> ni) | (x0 << (17-ni));
        r = x[15:0]; c = x[16];
      end
      3'd4: begin
        x = (x0 << ni) | (x0 >> (17-ni));
        r = x[15:0]; c = x[16];
        b0 = x0[15];
        for (int i = 1; i <= ni; i++) if (x0[(15-i+17)%17] != b0) v = 1'b1;
      end
      3'd5: begin r = (d >> ni) | (d << (16-ni)); c = r[15]; end
      3'd6: begin
        r = (d << ni) | (d >> (16-ni)); c = r[0];
        b0 = d[15];
        for (int i = 1; i <= ni; i++) if (d[(15-i+16)%16] != b0) v = 1'b1;
      end
      default: ;
    endcase
  endfunction

  task automatic drive_cen();
    if (cen_tog) cen = ~cen;
    else cen = 1'b1;
  endtask

  // Called right after a negedge; returns right after the negedge that
  // follows the first posedge with cen=1.
  task automatic next_cen_edge(output logic ok);
    logic hit;
    int guard;
    hit = 1'b0;
    guard = 0;
    while (!hit && guard < 10) begin
      @(posedge clk);
      hit = cen;
      @(negedge clk);
      drive_cen();
      guard++;
    end
    ok = hit;
  endtask

  task automatic run_op(input logic [2:0] m, input logic [15:0] d,
                        input logic [3:0] n, input logic ci);
    logic [15:0] er;
    logic ec, ev, ok, seen1, seen4, hit;
    int lat1, lat4, got1, got4, edges, guard;
    ref_model(m, d, n, ci, er, ec, ev);
    lat1 = (n == 0 || m == 3'd7) ? 0 : int'(n);
    lat4 = (n == 0 || m == 3'd7) ? 0 : (int'(n) + 3) / 4;
    mode = m; din = d; cnt = n; cin = ci; start = 1'b1;
    next_cen_edge(ok);
    check("launch", 32'(ok), 32'd1);
    start = 1'b0;
    mode = 3'($urandom); din = 16'($urandom); cnt = 4'($urandom); cin = 1'($urandom);
    check("busy1_at_launch", 32'(busy1), 32'(lat1 > 0));
    seen1 = done1; seen4 = done4; got1 = 0; got4 = 0; edges = 0; guard = 0;
    while (!(seen1 && seen4) && guard < 200) begin
      @(posedge clk);
      hit = cen;
      @(negedge clk);
      if (hit) edges++;
      if (!seen1 && done1) begin seen1 = 1'b1; got1 = edges; end
      if (!seen4 && done4) begin seen4 = 1'b1; got4 = edges; end
      drive_cen();
      guard++;
    end
    check("s1_done_seen", 32'(seen1), 32'd1);
    check("s4_done_seen", 32'(seen4), 32'd1);
    check("s1_latency", 32'(got1), 32'(lat1));
    check("s4_latency", 32'(got4), 32'(lat4));
    check("s1_dout", 32'(dout1), 32'(er));
    check("s1_c", 32'(c1), 32'(ec));
    check("s1_v", 32'(v1), 32'(ev));
    check("s1_z", 32'(z1), 32'(er == 16'h0));
    check("s1_n", 32'(n1), 32'(er[15]));
    check("s1_busy_end", 32'(busy1), 32'd0);
    check("s4_dout", 32'(dout4), 32'(er));
    check("s4_c", 32'(c4), 32'(ec));
    check("s4_v", 32'(v4), 32'(ev));
    check("s4_z", 32'(z4), 32'(er == 16'h0));
    check("s4_n", 32'(n4), 32'(er[15]));
    next_cen_edge(ok);
    check("s1_done_clears", 32'(done1), 32'd0);
    check("s1_dout_holds", 32'(dout1), 32'(er));
    $display("op mode=%0d din=%04h cnt=%0d cin=%0d -> dout=%04h c=%0d v=%0d lat1=%0d lat4=%0d cen_tog=%0d",
             m, d, n, ci, dout1, c1, v1, got1, got4, cen_tog);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy1"}, 32'(busy1), 32'd0);
    check({tag, "_done1"}, 32'(done1), 32'd0);
    check({tag, "_dout1"}, 32'(dout1), 32'd0);
    check({tag, "_cvzn1"}, 32'({c1, v1, z1, n1}), 32'b0010);
    check({tag, "_busy4"}, 32'(busy4), 32'd0);
    check({tag, "_done4"}, 32'(done4), 32'd0);
    check({tag, "_dout4"}, 32'(dout4), 32'd0);
    check({tag, "_cvzn4"}, 32'({c4, v4, z4, n4}), 32'b0010);
  endtask

  // LSR by 15, an ignored start while busy, then reset during the 5th shift.
  task automatic reset_mid_op(input logic [15:0] d);
    logic seen;
    mode = 3'd0; din = d; cnt = 4'd15; cin = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("mid_busy_launch", 32'(busy1), 32'd1);
    seen = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      if (e == 2) begin start = 1'b1; mode = 3'd2; din = ~d; cnt = 4'd3; cin = 1'b1; end
      else start = 1'b0;
      @(posedge clk); @(negedge clk);
      if (done1) seen = 1'b1;
    end
    start = 1'b0;
    check("mid_dout_after4", 32'(dout1), 32'(d >> 4));
    check("mid_busy_after4", 32'(busy1), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    check("mid_no_done", 32'(seen), 32'd0);
    @(negedge clk);
    check("mid_rst_no_done", 32'(done1), 32'd0);
    rst = 1'b0;
    $display("reset mid-op din=%04h dout1=%04h busy1=%0d", d, dout1, busy1);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; start = 1'b0; mode = 3'd0; din = 16'h0; cnt = 4'd0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 16'h8001, 4'd3, 1'b0);
    run_op(3'd1, 16'h8000, 4'd15, 1'b0);
    run_op(3'd2, 16'h4001, 4'd2, 1'b0);
    run_op(3'd4, 16'h8000, 4'd1, 1'b0);
    run_op(3'd5, 16'h0001, 4'd4, 1'b0);
    run_op(3'd0, 16'hFFFF, 4'd5, 1'b0);
    run_op(3'd2, 16'h0000, 4'd0, 1'b1);
    run_op(3'd7, 16'($urandom), 4'd9, 1'($urandom));
    run_op(3'd3, 16'h0001, 4'd15, 1'b1);
    run_op(3'd6, 16'h8000, 4'd15, 1'b0);

    cen_tog = 1'b1;
    run_op(3'd0, 16'hFFFF, 4'd5, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
    cen_tog = 1'b0;
    cen = 1'b1;
    @(negedge clk);

    reset_mid_op(16'hA5C3);
    run_op(3'd0, 16'h8001, 4'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] n;
      n = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      run_op(3'($urandom_range(0, 7)), 16'($urandom), n, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
